// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display arbiter:
//   arb_state_t : arbiter ownership state; the encoding doubles as the
//                 one-hot grant vector (IDLE=00, OWN0=01, OWN1=10).
//   SEG_BLANK   : all segments off (active-low).
//   AN_OFF      : all digit enables off (active-low).
//   hex7()      : hex nibble to active-low segment code, a=bit0 .. g=bit6,
//                 bit7 (dp) returned as 1 (off).
// -----------------------------------------------------------------------------
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } arb_state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'hF;

   function automatic logic [7:0] hex7(input logic [3:0] nib);
      logic [7:0] code;
      case (nib)
         4'h0:    code = 8'hC0;
         4'h1:    code = 8'hF9;
         4'h2:    code = 8'hA4;
         4'h3:    code = 8'hB0;
         4'h4:    code = 8'h99;
         4'h5:    code = 8'h92;
         4'h6:    code = 8'h82;
         4'h7:    code = 8'hF8;
         4'h8:    code = 8'h80;
         4'h9:    code = 8'h90;
         4'hA:    code = 8'h88;
         4'hB:    code = 8'h83;
         4'hC:    code = 8'hC6;
         4'hD:    code = 8'hA1;
         4'hE:    code = 8'h86;
         default: code = 8'h8E;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Free-running prescaler: counts 0..SCAN_DIV-1 and wraps. tick is high for
// the single cycle in which the count equals SCAN_DIV-1.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset (count returns to 0)
//   tick out one-cycle strobe per SCAN_DIV cycles
// -----------------------------------------------------------------------------
module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] tick_cnt_reg;

   assign tick = (tick_cnt_reg == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_reg <= '0;
      end else if (tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
// Shares a 4-digit active-low seven-segment display between two clients.
// Ownership changes only at scan-frame boundaries, round-robin on ties, and
// an owner that still wants the display keeps it for at least HOLD_FRAMES
// complete frames before a waiting client can preempt it.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   req[1:0] in   level requests, req[i] for client i
//   digits0  in   client 0 hex digits, nibble i -> digit i
//   dp0      in   client 0 decimal points, 1 = lit
//   digits1  in   client 1 hex digits
//   dp1      in   client 1 decimal points
//   grant    out  one-hot current owner, 00 when idle
//   seg      out  active-low segments a..g (bits 0..6), dp (bit 7)
//   an       out  active-low digit enables
// -----------------------------------------------------------------------------
module seg_display_arbiter
   import seg_pkg::*;
#(
   parameter int SCAN_DIV    = 100000,
   parameter int HOLD_FRAMES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [15:0] digits0,
   input  logic [3:0]  dp0,
   input  logic [15:0] digits1,
   input  logic [3:0]  dp1,
   output logic [1:0]  grant,
   output logic [7:0]  seg,
   output logic [3:0]  an
);

   // hold_cnt saturates at HOLD_FRAMES-1, so it never needs more range.
   localparam int HOLD_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES - 1);

   logic              tick;
   logic              frame_end;
   logic              hold_done;

   logic [1:0]        digit_idx_reg, digit_idx_next;
   arb_state_t        state_reg, state_next;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic              last_owner_reg, last_owner_next;
   logic [7:0]        seg_reg, seg_next;
   logic [3:0]        an_reg, an_next;

   logic [15:0]       client_digits [2];
   logic [3:0]        client_dp [2];
   logic [3:0]        an_sel;
   logic              owner_sel;
   logic [3:0]        owner_nib;
   logic [7:0]        hex_code;

   scan_tick_gen #(
      .SCAN_DIV (SCAN_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign client_digits[0] = digits0;
   assign client_digits[1] = digits1;
   assign client_dp[0]     = dp0;
   assign client_dp[1]     = dp1;

   // One-cold digit enable for the current slot.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_an_sel
         assign an_sel[gi] = (digit_idx_reg != 2'(gi));
      end
   endgenerate

   assign frame_end = tick && (digit_idx_reg == 2'd3);
   // Equivalent to hold_cnt+1 >= HOLD_FRAMES because hold_cnt saturates.
   assign hold_done = (hold_cnt_reg == HOLD_MAX);

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= IDLE;
         digit_idx_reg  <= 2'd0;
         hold_cnt_reg   <= '0;
         last_owner_reg <= 1'b1;
         seg_reg        <= SEG_BLANK;
         an_reg         <= AN_OFF;
      end else begin
         state_reg      <= state_next;
         digit_idx_reg  <= digit_idx_next;
         hold_cnt_reg   <= hold_cnt_next;
         last_owner_reg <= last_owner_next;
         seg_reg        <= seg_next;
         an_reg         <= an_next;
      end
   end

   // ---------------------------------------------------------------------
   // Arbitration: decisions are taken only at the frame boundary.
   // ---------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      hold_cnt_next   = hold_cnt_reg;
      last_owner_next = last_owner_reg;
      digit_idx_next  = tick ? digit_idx_reg + 2'd1 : digit_idx_reg;

      if (frame_end) begin
         case (state_reg)
            IDLE: begin
               case (req)
                  2'b01:   state_next = OWN0;
                  2'b10:   state_next = OWN1;
                  // Tie: the client that did not own last goes first.
                  2'b11:   state_next = last_owner_reg ? OWN0 : OWN1;
                  default: state_next = IDLE;
               endcase
            end
            OWN0: begin
               if (!req[0]) begin
                  state_next = req[1] ? OWN1 : IDLE;
               end else if (req[1] && hold_done) begin
                  state_next = OWN1;
               end else if (!hold_done) begin
                  hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
               end
            end
            OWN1: begin
               if (!req[1]) begin
                  state_next = req[0] ? OWN0 : IDLE;
               end else if (req[0] && hold_done) begin
                  state_next = OWN0;
               end else if (!hold_done) begin
                  hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
               end
            end
            default: state_next = IDLE;
         endcase

         // Any entry into an owned state restarts the hold window.
         if ((state_next != state_reg) && (state_next != IDLE)) begin
            hold_cnt_next   = '0;
            last_owner_next = (state_next == OWN1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Digit mux: uses the registered slot/owner, so the pins follow one
   // cycle after a slot or ownership change. Client data is sampled live.
   // ---------------------------------------------------------------------
   always_comb begin
      owner_sel = (state_reg == OWN1);
      owner_nib = client_digits[owner_sel][{digit_idx_reg, 2'b00} +: 4];
      hex_code  = hex7(owner_nib);
      seg_next  = SEG_BLANK;
      an_next   = AN_OFF;
      if ((state_reg == OWN0) || (state_reg == OWN1)) begin
         // hex7 leaves the dp bit off; clear it when the client lights it.
         seg_next = {hex_code[7] & ~client_dp[owner_sel][digit_idx_reg],
                     hex_code[6:0]};
         an_next  = an_sel;
      end
   end

   assign grant = state_reg;
   assign seg   = seg_reg;
   assign an    = an_reg;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
// Self-checking bench for seg_display_arbiter with SCAN_DIV=4, HOLD_FRAMES=2
// (one frame = 16 cycles). A cycle-count based reference model predicts
// grant/an/seg after every clock edge; directed scenarios add explicit
// expected values.
// -----------------------------------------------------------------------------
module tb_seg_display_arbiter;

   localparam int SD    = 4;
   localparam int HF    = 2;
   localparam int FRAME = 4 * SD;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [15:0] digits0, digits1;
   logic [3:0]  dp0, dp1;
   logic [1:0]  grant;
   logic [7:0]  seg;
   logic [3:0]  an;

   always #5 clk = ~clk;

   seg_display_arbiter #(
      .SCAN_DIV    (SD),
      .HOLD_FRAMES (HF)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .digits0 (digits0),
      .dp0     (dp0),
      .digits1 (digits1),
      .dp1     (dp1),
      .grant   (grant),
      .seg     (seg),
      .an      (an)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_total = 0;
   logic [1:0] prev_grant = 2'b00;

   // Reference model state: cycles since reset, owner (-1 = nobody),
   // complete frames held, last owner; plus predicted pins.
   int         m_cyc;
   int         m_owner;
   int         m_held;
   int         m_last;
   logic [1:0] m_grant;
   logic [7:0] m_seg;
   logic [3:0] m_an;

   logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                8'hC6, 8'hA1, 8'h86, 8'h8E};

   function automatic void m_enter(input int i);
      m_owner = i;
      m_held  = 0;
      m_last  = i;
   endfunction

   task automatic model_edge();
      int         slot;
      int         other;
      logic [15:0] d;
      logic [3:0]  p;
      logic [3:0]  nib;
      logic [7:0]  code;
      logic [3:0]  one;
      if (rst) begin
         m_cyc = 0; m_owner = -1; m_held = 0; m_last = 1;
         m_an = 4'hF; m_seg = 8'hFF; m_grant = 2'b00;
         return;
      end
      // Pins show the slot/owner that were in effect before this edge.
      slot = (m_cyc / SD) % 4;
      if (m_owner < 0) begin
         m_an  = 4'hF;
         m_seg = 8'hFF;
      end else begin
         d    = (m_owner == 0) ? digits0 : digits1;
         p    = (m_owner == 0) ? dp0 : dp1;
         nib  = 4'((d >> (4 * slot)) & 16'hF);
         code = hex_tbl[nib];
         one  = 4'b0001;
         m_an  = ~(one << slot);
         m_seg = {~p[slot], code[6:0]};
      end
      if ((m_cyc % FRAME) == FRAME - 1) begin
         if (m_owner < 0) begin
            if (req == 2'b01)      m_enter(0);
            else if (req == 2'b10) m_enter(1);
            else if (req == 2'b11) m_enter(1 - m_last);
         end else begin
            other = 1 - m_owner;
            if (!req[m_owner]) begin
               if (req[other]) m_enter(other);
               else            m_owner = -1;
            end else if (req[other] && (m_held + 1 >= HF)) begin
               m_enter(other);
            end else begin
               m_held++;
            end
         end
      end
      m_cyc++;
      m_grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
   endtask

   // Drive one cycle of inputs, advance the model over the edge, and return
   // at the following negedge where outputs are stable.
   task automatic step(input logic r_rst, input logic [1:0] r_req);
      rst = r_rst;
      req = r_req;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      cyc_total++;
      if (grant !== prev_grant)
         $display("txn cyc=%0d req=%b grant %b -> %b", cyc_total, r_req, prev_grant, grant);
      prev_grant = grant;
   endtask

   task automatic test_reset();
      step(1'b1, 2'b00);
      n_checks++;
      if ({grant, an, seg} !== {2'b00, 4'hF, 8'hFF}) begin
         n_fail++;
         $display("FAIL reset_state: got grant=%b an=%h seg=%h, want 00/F/FF", grant, an, seg);
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b0, 2'b00);
         n_checks++;
         if ({grant, an, seg} !== {2'b00, 4'hF, 8'hFF}) begin
            n_fail++;
            $display("FAIL idle_blank cyc%0d: got grant=%b an=%h seg=%h, want 00/F/FF", i, grant, an, seg);
         end
      end
   endtask

   task automatic test_single_owner();
      logic [3:0] exp_an_tbl  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
      logic [7:0] exp_seg_tbl [4] = '{8'hC0, 8'hB0, 8'h24, 8'hF9};
      int  got_at;
      got_at  = -1;
      digits0 = 16'h1230;
      dp0     = 4'b0100;
      step(1'b1, 2'b00);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 2'b01);
         n_checks++;
         if ({grant, an, seg} !== {m_grant, m_an, m_seg}) begin
            n_fail++;
            $display("FAIL single_model cyc%0d: got %b/%h/%h want %b/%h/%h", i, grant, an, seg, m_grant, m_an, m_seg);
         end
         if (grant === 2'b01) begin
            got_at = i;
            break;
         end
      end
      n_checks++;
      if (got_at != FRAME - 1) begin
         n_fail++;
         $display("FAIL grant_latency: granted at edge %0d, want %0d", got_at, FRAME - 1);
      end
      for (int k = 0; k < 16; k++) begin
         step(1'b0, 2'b01);
         n_checks++;
         if (an !== exp_an_tbl[k / 4] || seg !== exp_seg_tbl[k / 4]) begin
            n_fail++;
            $display("FAIL scan_seq k%0d: got an=%h seg=%h want an=%h seg=%h", k, an, seg, exp_an_tbl[k / 4], exp_seg_tbl[k / 4]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] chg_g [$];
      int         chg_i [$];
      logic [1:0] last_g;
      digits0 = 16'hABCD; dp0 = 4'b0001;
      digits1 = 16'h5678; dp1 = 4'b1000;
      step(1'b1, 2'b00);
      last_g = grant;
      for (int i = 0; i < 96; i++) begin
         step(1'b0, 2'b11);
         n_checks++;
         if ({grant, an, seg} !== {m_grant, m_an, m_seg}) begin
            n_fail++;
            $display("FAIL rr_model cyc%0d: got %b/%h/%h want %b/%h/%h", i, grant, an, seg, m_grant, m_an, m_seg);
         end
         if (grant !== last_g) begin
            chg_g.push_back(grant);
            chg_i.push_back(i);
            last_g = grant;
         end
      end
      n_checks++;
      if (chg_g.size() != 3) begin
         n_fail++;
         $display("FAIL rr_changes: got %0d grant changes, want 3", chg_g.size());
      end else if (chg_g[0] !== 2'b01 || chg_i[0] != 15 || chg_g[1] !== 2'b10 || chg_i[1] != 47 ||
                   chg_g[2] !== 2'b01 || chg_i[2] != 79) begin
         n_fail++;
         $display("FAIL rr_changes: got %b@%0d %b@%0d %b@%0d, want 01@15 10@47 01@79",
                  chg_g[0], chg_i[0], chg_g[1], chg_i[1], chg_g[2], chg_i[2]);
      end
   endtask

   task automatic test_handoff();
      bit done;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         step(1'b0, 2'b10);
         n_checks++;
         if (grant === 2'b00 || an === 4'hF) begin
            n_fail++;
            $display("FAIL handoff_gap cyc%0d: got grant=%b an=%h, want no blank", i, grant, an);
         end
         if (grant !== 2'b01) done = 1;
      end
      n_checks++;
      if (grant !== 2'b10) begin
         n_fail++;
         $display("FAIL handoff_grant: got %b want 10", grant);
      end
      step(1'b0, 2'b10);
      n_checks++;
      if ({grant, an, seg} !== {m_grant, m_an, m_seg} || an !== 4'hE) begin
         n_fail++;
         $display("FAIL handoff_first: got %b/%h/%h want %b/%h/%h (an E)", grant, an, seg, m_grant, m_an, m_seg);
      end
   endtask

   task automatic test_release();
      bit done;
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         step(1'b0, 2'b00);
         n_checks++;
         if ({grant, an, seg} !== {m_grant, m_an, m_seg}) begin
            n_fail++;
            $display("FAIL release_model cyc%0d: got %b/%h/%h want %b/%h/%h", i, grant, an, seg, m_grant, m_an, m_seg);
         end
         if (grant === 2'b00) done = 1;
      end
      n_checks++;
      if (!done || an !== 4'h7) begin
         n_fail++;
         $display("FAIL release_edge: got grant=%b an=%h, want 00 and an still 7", grant, an);
      end
      step(1'b0, 2'b00);
      n_checks++;
      if (an !== 4'hF || seg !== 8'hFF) begin
         n_fail++;
         $display("FAIL release_blank: got an=%h seg=%h want F/FF", an, seg);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit done;
      done = 0;
      step(1'b1, 2'b00);
      for (int i = 0; i < 40 && !done; i++) begin
         step(1'b0, 2'b10);
         if (grant === 2'b10) done = 1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL midrst_setup: got grant=%b want 10 within 40 cycles", grant);
      end
      for (int i = 0; i < 5; i++) step(1'b0, 2'b10);
      step(1'b1, 2'b10);
      n_checks++;
      if ({grant, an, seg} !== {2'b00, 4'hF, 8'hFF}) begin
         n_fail++;
         $display("FAIL midrst_blank: got %b/%h/%h want 00/F/FF", grant, an, seg);
      end
      done = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         step(1'b0, 2'b11);
         if (grant !== 2'b00) done = 1;
      end
      n_checks++;
      if (grant !== 2'b01) begin
         n_fail++;
         $display("FAIL midrst_tie: got grant=%b want 01", grant);
      end
   endtask

   task automatic test_random();
      logic [1:0] r_req;
      logic       r_rst;
      r_req = 2'b00;
      step(1'b1, 2'b00);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 7) == 0) r_req = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 31) == 0) begin
            digits0 = 16'($urandom); dp0 = 4'($urandom);
         end
         if ($urandom_range(0, 31) == 0) begin
            digits1 = 16'($urandom); dp1 = 4'($urandom);
         end
         r_rst = ($urandom_range(0, 399) == 0);
         step(r_rst, r_req);
         n_checks++;
         if ({grant, an, seg} !== {m_grant, m_an, m_seg}) begin
            n_fail++;
            $display("FAIL random cyc%0d: got %b/%h/%h want %b/%h/%h", i, grant, an, seg, m_grant, m_an, m_seg);
         end
      end
   endtask

   initial begin
      rst = 1'b1; req = 2'b00;
      digits0 = 16'h0000; dp0 = 4'h0;
      digits1 = 16'h0000; dp1 = 4'h0;
      m_cyc = 0; m_owner = -1; m_held = 0; m_last = 1;
      m_grant = 2'b00; m_an = 4'hF; m_seg = 8'hFF;
      @(negedge clk);
      test_reset();
      test_single_owner();
      test_round_robin();
      test_handoff();
      test_release();
      test_reset_mid_frame();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
